// File: rtl/alu_mc_if.sv
// ============================================================================
// alu_mc_if : request/result bundle between the controller and alu_mc
// Rev 1.0
// ============================================================================
`default_nettype none

interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       f;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, f, a, b,
    input  busy, done, y, zero, carry_out, overflow
  );

  modport slave (
    input  start, f, a, b,
    output busy, done, y, zero, carry_out, overflow
  );
endinterface

`default_nettype wire

// File: rtl/alu_mc.sv
// ============================================================================
// alu_mc : multicycle ALU, single-cycle logic/add/sub/slt, shift-add multiply
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_mc #(
  parameter int WIDTH = 32
) (
  input  wire logic  clk,
  input  wire logic  reset,
  alu_mc_if.slave    bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_y;
  logic               r_zero;
  logic               r_carry;
  logic               r_ovf;

  logic [WIDTH-1:0]   w_bb;
  logic [WIDTH:0]     w_sum;
  logic               w_sum_ovf;
  logic [WIDTH-1:0]   w_y;
  logic               w_c;
  logic               w_o;
  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_last;

  // f[2] selects inverted b plus carry-in, turning the adder into a subtractor
  assign w_bb      = bus.f[2] ? ~bus.b : bus.b;
  assign w_sum     = {1'b0, bus.a} + {1'b0, w_bb} + {{WIDTH{1'b0}}, bus.f[2]};
  assign w_sum_ovf = (bus.a[WIDTH-1] == w_bb[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);

  always_comb begin
    w_y = '0;
    w_c = 1'b0;
    w_o = 1'b0;
    case (bus.f[1:0])
      2'b00: w_y = bus.a & w_bb;
      2'b01: w_y = bus.a | w_bb;
      2'b10: begin
        w_y = w_sum[WIDTH-1:0];
        w_c = w_sum[WIDTH];
        w_o = w_sum_ovf;
      end
      default: w_y[0] = w_sum[WIDTH-1] ^ w_sum_ovf;
    endcase
  end

  assign w_addend  = r_mplier[0] ? ({{WIDTH{1'b0}}, r_mcand} << r_count) : '0;
  assign w_acc_nxt = r_acc + w_addend;
  assign w_last    = (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_y      <= '0;
      r_zero   <= 1'b1;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.f == 3'b011) begin
              r_mcand  <= bus.a;
              r_mplier <= bus.b;
              r_acc    <= '0;
              r_count  <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_MUL;
            end else begin
              r_y     <= w_y;
              r_zero  <= (w_y == '0);
              r_carry <= w_c;
              r_ovf   <= w_o;
              r_done  <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
          if (w_last) begin
            r_y     <= w_acc_nxt[WIDTH-1:0];
            r_zero  <= (w_acc_nxt[WIDTH-1:0] == '0);
            r_carry <= |w_acc_nxt[2*WIDTH-1:WIDTH];
            r_ovf   <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.y         = r_y;
  assign bus.zero      = r_zero;
  assign bus.carry_out = r_carry;
  assign bus.overflow  = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_alu_mc.sv
// ============================================================================
// tb_alu_mc : directed self-checking bench for alu_mc (WIDTH 32 and 8)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_mc;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  alu_mc_if #(.WIDTH(32)) bus  ();
  alu_mc_if #(.WIDTH(8))  bus8 ();

  alu_mc #(.WIDTH(32)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
  alu_mc #(.WIDTH(8))  u_dut8 (.clk(clk), .reset(reset), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // returns at the falling edge right after the sampling edge
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.f     = f;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [31:0] y, input logic c,
                           input logic o, input logic z);
    check({tag, ".done"}, 64'(bus.done), 64'(1'b1));
    check({tag, ".y"},    64'(bus.y), 64'(y));
    check({tag, ".c"},    64'(bus.carry_out), 64'(c));
    check({tag, ".o"},    64'(bus.overflow), 64'(o));
    check({tag, ".z"},    64'(bus.zero), 64'(z));
  endtask

  // MUL on the 32-bit instance; optionally pokes an ADD start while busy
  task automatic mul32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input bit inject, input logic [31:0] y, input logic c, input logic z);
    int lat;
    int busy_cnt;
    int done_cnt;
    lat = -1;
    busy_cnt = 0;
    done_cnt = 0;
    issue(3'b011, a, b);
    for (int k = 0; k < 48; k++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = k;
          check({tag, ".y"}, 64'(bus.y), 64'(y));
          check({tag, ".c"}, 64'(bus.carry_out), 64'(c));
          check({tag, ".z"}, 64'(bus.zero), 64'(z));
          check({tag, ".o"}, 64'(bus.overflow), 64'(1'b0));
        end
      end
      if (inject && k == 5) begin
        bus.start = 1'b1; bus.f = 3'b010; bus.a = 32'd1; bus.b = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, ".lat"},   64'(lat), 64'(32));
    check({tag, ".busy"},  64'(busy_cnt), 64'(32));
    check({tag, ".ndone"}, 64'(done_cnt), 64'(1));
    check({tag, ".yhold"}, 64'(bus.y), 64'(y));
  endtask

  initial begin
    int cnt;
    int lat8;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.start = 1'b0;  bus.f = 3'b000;  bus.a = '0;  bus.b = '0;
    bus8.start = 1'b0; bus8.f = 3'b000; bus8.a = '0; bus8.b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst.busy", 64'(bus.busy), 64'(1'b0));
    check("rst.y",    64'(bus.y), 64'(0));
    check("rst.z",    64'(bus.zero), 64'(1'b1));
    check("rst.c",    64'(bus.carry_out), 64'(1'b0));
    check("rst.o",    64'(bus.overflow), 64'(1'b0));
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    check("idle.ndone", 64'(cnt), 64'(0));

    issue(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
    check_res("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);

    // asynchronous reset mid-cycle must clear outputs without a clock edge
    #2 reset = 1'b1;
    #1;
    check("arst.done", 64'(bus.done), 64'(1'b0));
    check("arst.y",    64'(bus.y), 64'(0));
    check("arst.z",    64'(bus.zero), 64'(1'b1));
    check("arst.o",    64'(bus.overflow), 64'(1'b0));
    @(negedge clk);
    reset = 1'b0;

    issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0001);
    check_res("add_c", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("pulse.done", 64'(bus.done), 64'(1'b0));

    issue(3'b110, 32'd5, 32'd5);
    check_res("sub", 32'h0, 1'b1, 1'b0, 1'b1);
    issue(3'b000, 32'h1234_5678, 32'h0F0F_0F0F);
    check_res("and", 32'h0204_0608, 1'b0, 1'b0, 1'b0);
    issue(3'b001, 32'h1234_0000, 32'h0000_5678);
    check_res("or", 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    issue(3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check_res("andn", 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
    issue(3'b101, 32'h0000_0000, 32'hFFFF_0000);
    check_res("orn", 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
    issue(3'b111, 32'h8000_0000, 32'h0000_0001);
    check_res("slt1", 32'h1, 1'b0, 1'b0, 1'b0);
    issue(3'b111, 32'h0000_0001, 32'h8000_0000);
    check_res("slt0", 32'h0, 1'b0, 1'b0, 1'b1);

    @(negedge clk);
    bus.start = 1'b1; bus.f = 3'b010; bus.a = 32'd1; bus.b = 32'd2;
    @(negedge clk);
    check_res("b2b1", 32'd3, 1'b0, 1'b0, 1'b0);
    bus.a = 32'd10; bus.b = 32'd20;
    @(negedge clk);
    check_res("b2b2", 32'd30, 1'b0, 1'b0, 1'b0);
    bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    check_res("b2b3", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b.end", 64'(bus.done), 64'(1'b0));

    mul32("mul1", 32'h0000_FFFF, 32'h0001_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    mul32("mul2", 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    mul32("mulrej", 32'd3, 32'd5, 1'b1, 32'd15, 1'b0, 1'b0);

    issue(3'b011, 32'h1234_5678, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    check("mrst.busy0", 64'(bus.busy), 64'(1'b1));
    #2 reset = 1'b1;
    #1;
    check("mrst.busy", 64'(bus.busy), 64'(1'b0));
    check("mrst.y",    64'(bus.y), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) cnt++;
    end
    check("mrst.quiet", 64'(cnt), 64'(0));
    issue(3'b010, 32'd4, 32'd5);
    check_res("mrst.add", 32'd9, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    bus8.start = 1'b1; bus8.f = 3'b011; bus8.a = 8'h0F; bus8.b = 8'h11;
    @(negedge clk);
    bus8.start = 1'b0;
    lat8 = -1;
    for (int k = 0; k < 20; k++) begin
      if (bus8.done && lat8 < 0) begin
        lat8 = k;
        check("mul8.y", 64'(bus8.y), 64'(8'hFF));
        check("mul8.c", 64'(bus8.carry_out), 64'(1'b0));
      end
      @(negedge clk);
    end
    check("mul8.lat", 64'(lat8), 64'(8));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/alu_mc.md
# alu_mc

Parametrised multicycle ALU: successor to the combinational 32-bit `alu`, with a start/done handshake, registered result and flags, and an iterative shift-add multiply on the previously unused function code. It sits between the datapath register file and writeback; a controller issues one operation at a time and stalls on `busy`.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled on a rising edge of `clk` only while `busy`=0.
- `f`  in  3  function code, sampled with `start`.
- `a`  in  WIDTH  operand A, sampled with `start`.
- `b`  in  WIDTH  operand B, sampled with `start`.
- `busy`  out  1  multiply in progress; new `start` is ignored.
- `done`  out  1  one-cycle pulse: `y` and the flags are updated this cycle.
- `y`  out  WIDTH  registered result; holds until the next `done`.
- `zero`  out  1  registered; 1 iff `y` == 0.
- `carry_out`  out  1  registered carry/unsigned-overflow flag.
- `overflow`  out  1  registered signed-overflow flag.

## Operation
- Function codes, where `bb` = `f[2]` ? ~`b` : `b`:
  - 000: `a` & `b`.
  - 001: `a` | `b`.
  - 010: `a` + `b`.
  - 011: MUL, the low WIDTH bits of unsigned `a`×`b`.
  - 100: `a` & ~`b`.
  - 101: `a` | ~`b`.
  - 110: `a` − `b`, computed as `a` + ~`b` + 1.
  - 111: SLT. `y` = {0…0, sign of (`a` − `b`) XOR signed overflow of that subtraction}.
- Flags:
  - ADD/SUB: `carry_out` is bit WIDTH of the WIDTH+1-bit sum. `overflow` = operands' effective signs equal AND result sign differs.
  - Logic ops and SLT: `carry_out` = 0, `overflow` = 0.
  - MUL: `carry_out` = 1 iff the upper WIDTH bits of the full 2·WIDTH product are nonzero. `overflow` = 0.
  - `zero` is always recomputed from the new `y`.
- State machine: IDLE, MUL.
  - IDLE, `start`=1, `f`≠011: compute combinationally, register `y`/flags, pulse `done` next cycle, stay IDLE.
  - IDLE, `start`=1, `f`=011: latch multiplicand = `a`, multiplier = `b`, acc = 0 (2·WIDTH bits), count = 0; `busy`←1; go to MUL.
  - MUL, each cycle: if multiplier[0], acc += multiplicand (zero-extended, shifted by count). Then shift the multiplier right 1 and count += 1.
  - MUL exit: on the edge completing the iteration with count = WIDTH−1, register `y` = acc[WIDTH−1:0] and the flags, `done`←1, `busy`←0, go to IDLE.
  - Count width is $clog2(WIDTH)+1.
- `start` while `busy`=1 is ignored; operands are not re-sampled and no `done` is generated for it.
- `done` is never held longer than one cycle. Back-to-back single-cycle ops produce `done` every cycle.

## Timing
- Reset (asynchronous, takes effect immediately, mid-multiply included):
  - State IDLE; `busy`=0, `done`=0, `y`=0, `zero`=1, `carry_out`=0, `overflow`=0.
  - Accumulator and count cleared; no `done` for the aborted operation.
- Single-cycle ops:
  - `start` sampled at edge N → `y`/flags valid and `done`=1 after edge N, for the cycle N→N+1.
  - `busy` stays 0, so a new `start` can be accepted at edge N+1.
- MUL:
  - `start` sampled at edge N → `busy`=1 after edge N.
  - Iterations occur at edges N+1 … N+WIDTH.
  - `y` valid and `done`=1 after edge N+WIDTH; `busy`=0 from that same edge.
  - A new `start` is accepted at edge N+WIDTH+1 at the earliest.
- Operand inputs may change freely after the sampling edge.
- Outputs are glitch-free registers; there is no combinational path from inputs to outputs.

## Test plan
- Reset then idle: assert `reset` mid-cycle → all outputs immediately take their reset values (`zero`=1); no `done` while `start`=0.
- ADD/SUB flags (WIDTH=32):
  - ADD 7FFFFFFF+00000001 → 80000000, `overflow`=1, `carry_out`=0, `done` 1 cycle later.
  - ADD FFFFFFFF+00000001 → 00000000, `zero`=1, `carry_out`=1.
  - SUB 5−5 → 0, `zero`=1, `carry_out`=1.
- Logic and SLT: f=100 with F0F0F0F0, FF00FF00 → 00F000F0. SLT 80000000 vs 00000001 → 1. SLT 00000001 vs 80000000 → 0.
- MUL:
  - 0000FFFF×00010001 → FFFFFFFF, `carry_out`=0, `done` exactly 32 cycles after accept, `busy` high for 32 cycles.
  - 00010000×00010000 → 00000000, `zero`=1, `carry_out`=1.
- Busy rejection: during MUL, pulse `start` with ADD 1+1 → ignored; only the MUL `done` appears and `y` = MUL result.
- Reset mid-multiply and back-to-back ops:
  - `reset` at iteration 10 → IDLE, `busy`=0, no `done`.
  - Then three consecutive ADD starts → three consecutive `done` pulses with correct `y` values.
  - Repeat the MUL case at WIDTH=8: 0F×11 → FF, latency 8 cycles.
